// File: rtl/wb_initiator_if.sv
// Command, response and Wishbone classic master signals of wb_initiator.
// master: the initiator's view; slave: the view of whatever drives commands and acks.
interface wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle, one response out.
// Define WB_INITIATOR_TIMEOUT_EN to abort bus cycles not acked within TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | ready for a command, bus outputs zero
// BUS   | cyc/stb asserted with latched command, waiting for ack
// RESP  | response held until consumer takes it
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_initiator_if.master   bus,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("wb_initiator: TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = BUS;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_addr;
          dat_d   = bus.cmd_wdata;
`ifdef WB_INITIATOR_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      BUS: begin
        // Ack beats the timeout when both land in the same cycle.
        if (bus.wbm_ack_i) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : bus.wbm_dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rdata_q <= 32'd0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  logic in_bus;
  assign in_bus = (state_q == BUS);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign bus.wbm_cyc_o = in_bus;
  assign bus.wbm_stb_o = in_bus;
  assign bus.wbm_we_o  = in_bus & we_q;
  assign bus.wbm_sel_o = in_bus ? sel_q : 4'd0;
  assign bus.wbm_adr_o = in_bus ? adr_q : 32'd0;
  assign bus.wbm_dat_o = in_bus ? dat_q : 32'd0;

  assign busy = (state_q != IDLE);

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, bus cycles waited for wbm_ack_i before abort (1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this cycle when cmd_valid also high.
REQ-006 SHALL have ports cmd_we input 1, cmd_sel input 4, cmd_addr input 32, cmd_wdata input 32: write flag, byte lanes, byte address, write data.
REQ-007 SHALL have port rsp_valid  output  1  response held for consumer.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-009 SHALL have ports rsp_rdata output 32, rsp_err output 1: read data, timeout flag.
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o output 1; wbm_sel_o output 4; wbm_adr_o, wbm_dat_o output 32: Wishbone classic master outputs.
REQ-011 SHALL have ports wbm_dat_i input 32, wbm_ack_i input 1: Wishbone slave return.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, BUS, RESP.
REQ-014 cmd_ready SHALL be high only in IDLE (registered-state decode, no dependence on cmd_valid).
REQ-015 IDLE: cmd_valid&&cmd_ready SHALL latch we/sel/addr/wdata and go to BUS; wbm_cyc_o=wbm_stb_o=1 from the next cycle.
REQ-016 In BUS, wbm_adr_o/dat_o/sel_o/we_o SHALL equal latched values and stay stable until ack or abort.
REQ-017 BUS with wbm_ack_i=1: capture wbm_dat_i into rsp_rdata when latched we=0 (rsp_rdata=0 for writes), rsp_err=0, go to RESP; cyc/stb low the following cycle.
REQ-018 Single-access latency: cmd accept edge N, cyc/stb high N+1, ack sampled at edge M, rsp_valid high from M+1; minimum 2 cycles accept-to-rsp_valid.
REQ-019 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then IDLE next cycle; rsp_valid low in IDLE/BUS.
REQ-020 No new command SHALL be accepted in the cycle the response is consumed (back-to-back issue = 1 idle cycle min).
REQ-021 wbm_ack_i outside BUS SHALL be ignored (no state change, no capture).
REQ-022 wbm_cyc_o and wbm_stb_o SHALL always be equal; never high outside BUS.
REQ-023 wbm_we_o/sel_o/adr_o/dat_o SHALL be 0 outside BUS.

Reset
REQ-024 reset_n low at a rising edge SHALL force IDLE, cyc/stb/we=0, sel/adr/dat_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0; cmd_ready=1 after release.
REQ-025 Reset in BUS SHALL drop cyc/stb at that edge with no response generated; reset in RESP SHALL discard the pending response.

Configuration
REQ-026 Macro WB_INITIATOR_TIMEOUT_EN defined: 16-bit counter cleared on entering BUS, incremented each BUS cycle without ack; when count reaches TIMEOUT_CYCLES-1 without ack, go to RESP with rsp_err=1, rsp_rdata=0, cyc/stb low next cycle (transaction spans exactly TIMEOUT_CYCLES cycles with cyc high).
REQ-027 Ack in the same cycle the count reaches TIMEOUT_CYCLES-1 SHALL win (normal completion, rsp_err=0).
REQ-028 Macro undefined: no counter; BUS waits for ack indefinitely; rsp_err tied 0.

Verification
REQ-029 Read: cmd addr=0x3000_0004 we=0 sel=0xF, slave acks 2nd cyc cycle with 0xDEADBEEF -> one 2-cycle cyc/stb pulse, rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 Write: addr=0x3000_0000 wdata=0x1234_5678 sel=0x3 we=1, immediate ack -> wbm_dat_o=0x12345678, sel=0x3, we=1 for 1 cycle; rsp_rdata=0, rsp_err=0.
REQ-031 Backpressure: rsp_ready low 10 cycles, cmd_valid held high -> rsp held stable, cmd_ready low throughout, second command accepted 1 cycle after consumption.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=8): no ack -> cyc high exactly 8 cycles, rsp_err=1, rsp_rdata=0; macro off -> cyc stays high 1000 cycles, no rsp_valid.
REQ-033 Reset mid-BUS at cycle 3 of wait -> cyc/stb low at that edge, rsp_valid never asserts, next command completes normally.
REQ-034 Spurious wbm_ack_i pulses in IDLE and RESP -> no state change, rsp_rdata unchanged.
